lane_mux_serializer: RTL and testbench
======================================

Name: lane_mux_serializer

Overview:
- Sequential N-to-1 recombiner. It is the transmit-side counterpart of the 1-to-N lane demultiplexers.
- Captures one parallel word of N_LANES lanes and emits the lanes one per accepted beat, lane 0 first, on a single serial output.
- Valid/ready on both sides. Sits in the Zigbee TX chip path, between the per-lane symbol/chip generators and the modulator front end.

Parameters:
- N_LANES, 8, number of input lanes; must be >= 2.
- DATA_W, 1, bits per lane.
- SEL_W, $clog2(N_LANES), width of the lane index.

Ports:
- inClk  input  1  clock; all logic is on the rising edge.
- inRst  input  1  synchronous, active-high reset.
- inData  input  N_LANES*DATA_W  parallel lanes; lane k occupies bits [k*DATA_W +: DATA_W].
- inValid  input  1  inData is valid.
- inReady  output  1  block can accept a new word.
- outData  output  DATA_W  current serial lane value.
- outSel  output  SEL_W  index of the lane currently on outData.
- outValid  output  1  outData/outSel are valid.
- outReady  input  1  downstream accepts the current beat.

Behaviour:
- Reset (inRst=1 at a clock edge):
  - State goes to IDLE.
  - inReady=1, outValid=0, outData=0, outSel=0, capture register cleared.
  - Reset wins over any simultaneous handshake. A word in flight when reset hits is discarded with no partial flush.
- States: IDLE, SEND.
- IDLE:
  - inReady=1, outValid=0.
  - inValid=1 → capture inData into holdReg, set outSel=0, go to SEND.
  - Latency: lane 0 appears on outData the cycle after capture.
- SEND:
  - outValid=1. outData = holdReg lane[outSel], from a combinational select on registered state.
  - Beat accepted (outValid & outReady):
    - outSel < N_LANES-1 → outSel increments.
    - outSel = N_LANES-1 → end of word; see the next bullet.
  - outReady=0 → outData and outSel hold stable; stalls of any length are allowed.
- inReady in SEND = outReady & (outSel == N_LANES-1). This allows back-to-back words:
  - Last beat accepted and inValid=1 in the same cycle → capture the new word, outSel wraps to 0, stay in SEND. No bubble.
  - Last beat accepted and inValid=0 → go to IDLE.
- Throughput: one lane per cycle sustained; N_LANES cycles per word with no gap.
- inData is sampled only on the capture edge. Changes at any other time have no effect.
- outSel wrap: arithmetic is modulo N_LANES, not 2^SEL_W. For non-power-of-2 N_LANES, outSel never exceeds N_LANES-1.
- inValid with inReady=0 is ignored. The upstream must hold the word until it is accepted.

Optional Feature:
- Macro: LANE_MUX_LAST_EN.
- Defined:
  - Adds output port outLast (1 bit).
  - outLast = outValid & (outSel == N_LANES-1); reset value 0.
  - Marks the final lane of each word for the modulator framing logic.
- Not defined: the port is absent and the behaviour is otherwise identical.

Decomposition:
- Package zb_lane_mux_pkg holds:
  - state enum lane_mux_state_t {IDLE, SEND};
  - default constants LANE_MUX_N_LANES_DEF=8 and LANE_MUX_DATA_W_DEF=1.
- Sub-module mux_n21: a purely combinational N_LANES-to-1 selector (inData, inSel → outData).
  - It is the direct inverse of the existing demultiplexers and is reusable elsewhere.
  - lane_mux_serializer instantiates one mux_n21 on holdReg/outSel.

Test Plan:
- Reset: hold inRst=1 for 3 cycles with inValid=1, inData=8'hA5 → inReady=1, outValid=0, outSel=0 throughout; no capture after release until inValid is sampled again.
- Single word, outReady=1 constant: inData=8'b1011_0010 → outData sequence 0,1,0,0,1,1,0,1 on outSel 0..7, one per cycle, starting 1 cycle after capture; then IDLE.
- Back-to-back: words 8'hFF then 8'h00 with inValid held → 16 consecutive valid beats (eight 1s then eight 0s), no idle cycle; inReady pulses exactly on each outSel=7 accept.
- Backpressure: outReady=0 for 5 cycles at outSel=3 → outData, outSel stable; inData toggling has no effect; resumes at outSel=4 when outReady=1.
- Mid-word reset: inRst=1 at outSel=5 → next cycle outValid=0, outSel=0, IDLE; the following word starts at lane 0.
- N_LANES=4, DATA_W=4, LANE_MUX_LAST_EN defined: inData=16'h4321 → outData 1,2,3,4; outLast=1 only with outData=4.

Source files
------------

// File: rtl/zb_lane_mux_pkg.sv
// Shared types and default sizing for the Zigbee TX lane recombiner.
package zb_lane_mux_pkg;

  localparam int unsigned LANE_MUX_N_LANES_DEF = 8;
  localparam int unsigned LANE_MUX_DATA_W_DEF  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } lane_mux_state_t;

endpackage

// File: rtl/lane_mux_serializer_mux_n21.sv
// Combinational N-to-1 lane selector; inverse of the 1-to-N lane demultiplexers.
module mux_n21
  import zb_lane_mux_pkg::*;
#(
  parameter int unsigned N_LANES = LANE_MUX_N_LANES_DEF,
  parameter int unsigned DATA_W  = LANE_MUX_DATA_W_DEF,
  parameter int unsigned SEL_W   = $clog2(N_LANES)
) (
  input  logic [N_LANES*DATA_W-1:0] inData,
  input  logic [SEL_W-1:0]          inSel,
  output logic [DATA_W-1:0]         outData
);

  // Out-of-range selects (non power-of-2 lane counts) return zero.
  always_comb begin
    outData = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (inSel == SEL_W'(k)) begin
        outData = inData[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/lane_mux_serializer.sv
// Captures an N_LANES-wide word and emits it one lane per accepted beat, lane 0 first.
// Optional outLast end-of-word marker enabled by defining LANE_MUX_LAST_EN.
module lane_mux_serializer
  import zb_lane_mux_pkg::*;
#(
  parameter int unsigned N_LANES = LANE_MUX_N_LANES_DEF,
  parameter int unsigned DATA_W  = LANE_MUX_DATA_W_DEF,
  parameter int unsigned SEL_W   = $clog2(N_LANES)
) (
  input  logic                      inClk,
  input  logic                      inRst,
  input  logic [N_LANES*DATA_W-1:0] inData,
  input  logic                      inValid,
  output logic                      inReady,
  output logic [DATA_W-1:0]         outData,
  output logic [SEL_W-1:0]          outSel,
  output logic                      outValid,
  input  logic                      outReady
`ifdef LANE_MUX_LAST_EN
  ,
  output logic                      outLast
`endif
);

  localparam int unsigned      WORD_W   = N_LANES * DATA_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_LANES - 1);

  lane_mux_state_t   state;
  logic [WORD_W-1:0] hold_reg;
  logic [SEL_W-1:0]  sel;
  logic              last_c;
  logic              beat_c;
  logic              take_c;

  assign last_c   = (sel == LAST_SEL);
  assign outValid = (state == SEND);
  assign beat_c   = outValid & outReady;
  // Accepting on the final beat lets consecutive words stream with no bubble.
  assign inReady  = (state == IDLE) | (outReady & last_c);
  assign take_c   = inReady & inValid;
  assign outSel   = sel;

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state    <= IDLE;
      hold_reg <= '0;
      sel      <= '0;
    end else if (take_c) begin
      state    <= SEND;
      hold_reg <= inData;
      sel      <= '0;
    end else if (beat_c) begin
      if (last_c) begin
        state <= IDLE;
        sel   <= '0;
      end else begin
        sel <= sel + SEL_W'(1);
      end
    end
  end

  mux_n21 #(
    .N_LANES (N_LANES),
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W)
  ) u_mux (
    .inData  (hold_reg),
    .inSel   (sel),
    .outData (outData)
  );

`ifdef LANE_MUX_LAST_EN
  assign outLast = outValid & last_c;
`endif

endmodule

// File: tb/tb_lane_mux_serializer.sv
// Randomized bench for lane_mux_serializer against a queue-based beat model.
// Build with LANE_MUX_LAST_EN to exercise the 4x4-bit configuration and outLast.
module tb_lane_mux_serializer;

`ifdef LANE_MUX_LAST_EN
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
`else
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 1;
`endif
  localparam int unsigned SW = $clog2(N);
  localparam int unsigned W  = N * DW;
  localparam logic [W-1:0] RST_PAT = W'(32'hA5A5_A5A5);

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   sel;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sel;
  logic          out_valid;
  logic          out_ready;
`ifdef LANE_MUX_LAST_EN
  logic          out_last;
`endif

  int checks   = 0;
  int failures = 0;

  beat_t        exp_q[$];
  logic [W-1:0] src_q[$];
  int  stall_at  = -1;
  int  stall_len = 0;
  int  rst_at    = -1;
  bit  rnd_ready = 1'b0;
  bit  rnd_rst   = 1'b0;
  bit  started   = 1'b0;
  bit  after_rst = 1'b0;

  always #5 clk = ~clk;

  lane_mux_serializer #(
    .N_LANES (N),
    .DATA_W  (DW),
    .SEL_W   (SW)
  ) dut (
    .inClk    (clk),
    .inRst    (rst),
    .inData   (in_data),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .outData  (out_data),
    .outSel   (out_sel),
    .outValid (out_valid),
    .outReady (out_ready)
`ifdef LANE_MUX_LAST_EN
    ,
    .outLast  (out_last)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance the model.
  task automatic tick(input bit force_rst);
    bit           r;
    bit           ordy;
    bit           iv;
    bit           ev;
    bit           exp_ir;
    bit           acc_in;
    bit           acc_out;
    logic [W-1:0] id;
    beat_t        b;
    r    = force_rst;
    ordy = 1'b1;
    if (rnd_ready) ordy = ($urandom_range(0, 3) != 0);
    if (exp_q.size() > 0) begin
      if (stall_len > 0 && exp_q[0].sel == stall_at) begin
        ordy = 1'b0;
        stall_len--;
      end
      if (rst_at >= 0 && exp_q[0].sel == rst_at) begin
        r      = 1'b1;
        rst_at = -1;
      end
    end
    if (rnd_rst && $urandom_range(0, 99) == 0) r = 1'b1;
    iv = (src_q.size() > 0);
    id = iv ? src_q[0] : W'($urandom());
    if (force_rst && !iv) begin
      iv = 1'b1;
      id = RST_PAT;
    end
    rst       = r;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    ev     = (exp_q.size() > 0);
    exp_ir = !ev || (exp_q.size() == 1 && ordy);
    if (started) begin
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        check("out_sel", 32'(out_sel), exp_q[0].sel);
      end else if (after_rst) begin
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
      end
`ifdef LANE_MUX_LAST_EN
      check("out_last", 32'(out_last), 32'(ev && exp_q[0].sel == N - 1));
`endif
    end
    acc_out = ev && ordy;
    acc_in  = iv && exp_ir;
    if (r) begin
      exp_q.delete();
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (acc_out) void'(exp_q.pop_front());
      if (acc_in) begin
        for (int k = 0; k < int'(N); k++) begin
          b.data = id[k*DW +: DW];
          b.sel  = k;
          exp_q.push_back(b);
        end
        void'(src_q.pop_front());
      end
    end
    @(negedge clk);
    started = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    repeat (3) tick(1'b1);
    repeat (4) tick(1'b0);

`ifdef LANE_MUX_LAST_EN
    src_q.push_back(16'h4321);
    repeat (8) tick(1'b0);
`else
    src_q.push_back(8'b1011_0010);
    repeat (12) tick(1'b0);

    src_q.push_back(8'hFF);
    src_q.push_back(8'h00);
    repeat (20) tick(1'b0);

    stall_at  = 3;
    stall_len = 5;
    src_q.push_back(8'b0110_1001);
    repeat (16) tick(1'b0);

    rst_at = 5;
    src_q.push_back(8'hA7);
    src_q.push_back(8'h5E);
    repeat (20) tick(1'b0);
`endif

    rnd_ready = 1'b1;
    rnd_rst   = 1'b1;
    repeat (1500) begin
      if (src_q.size() == 0 && $urandom_range(0, 2) == 0) src_q.push_back(W'($urandom()));
      tick(1'b0);
    end
    rnd_ready = 1'b0;
    rnd_rst   = 1'b0;
    repeat (3 * N + 4) tick(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
